// File: rtl/axis_spm_control_gen.sv
// SPM XYZU control mixer: rotates scan coords, adds slew-limited offsets, a slope plane and
// the Z servo/GVP terms, and produces saturated X/Y/Z/U streams on a decimated update tick.
module axis_spm_control_gen #(
    parameter int unsigned W      = 32,
    parameter int unsigned QROTM  = 28,
    parameter int unsigned QSLOPE = 22,
    parameter int unsigned RDECI  = 4
) (
    input  logic         a_clk,
    input  logic         a_rst,
    input  logic [W-1:0] S_AXIS_Xs_tdata,
    input  logic         S_AXIS_Xs_tvalid,
    input  logic [W-1:0] S_AXIS_Ys_tdata,
    input  logic         S_AXIS_Ys_tvalid,
    input  logic [W-1:0] S_AXIS_Zs_tdata,
    input  logic         S_AXIS_Zs_tvalid,
    input  logic [W-1:0] S_AXIS_Z_tdata,
    input  logic [W-1:0] S_AXIS_U_tdata,
    input  logic [W-1:0] rotmxx,
    input  logic [W-1:0] rotmxy,
    input  logic [W-1:0] slope_x,
    input  logic [W-1:0] slope_y,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] z0,
    input  logic [W-1:0] u0,
    input  logic [W-1:0] xy_offset_step,
    input  logic [W-1:0] z_offset_step,
    output logic [W-1:0] M_AXIS1_tdata,
    output logic         M_AXIS1_tvalid,
    output logic [W-1:0] M_AXIS2_tdata,
    output logic         M_AXIS2_tvalid,
    output logic [W-1:0] M_AXIS3_tdata,
    output logic         M_AXIS3_tvalid,
    output logic [W-1:0] M_AXIS4_tdata,
    output logic         M_AXIS4_tvalid,
    output logic [W-1:0] M_AXIS_XSMON_tdata,
    output logic         M_AXIS_XSMON_tvalid,
    output logic [W-1:0] M_AXIS_YSMON_tdata,
    output logic         M_AXIS_YSMON_tvalid,
    output logic [W-1:0] M_AXIS_ZSMON_tdata,
    output logic         M_AXIS_ZSMON_tvalid,
    output logic [W-1:0] M_AXIS_X0MON_tdata,
    output logic         M_AXIS_X0MON_tvalid,
    output logic [W-1:0] M_AXIS_Y0MON_tdata,
    output logic         M_AXIS_Y0MON_tvalid,
    output logic [W-1:0] M_AXIS_Z0MON_tdata,
    output logic         M_AXIS_Z0MON_tvalid,
    output logic [W-1:0] M_AXIS_UrefMON_tdata,
    output logic         M_AXIS_UrefMON_tvalid,
    output logic [2:0]   offset_settled,
    output logic         z_sat
);
    localparam int unsigned PW  = 2 * W + 1;
    localparam int unsigned ZW  = W + 4;
    localparam int unsigned ZPW = W + PW + 1;
    localparam int unsigned SW  = W + 5;
    localparam logic signed [PW-1:0]  MaxW = {{(PW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [ZPW-1:0] MaxZ = {{(ZPW - ZW + 1){1'b0}}, {(ZW - 1){1'b1}}};

    function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] mn;
        mn = -MaxW;
        if (v > MaxW) return MaxW[W-1:0];
        if (v < mn) return mn[W-1:0];
        return v[W-1:0];
    endfunction

    function automatic logic signed [ZW-1:0] sat_z(input logic signed [ZPW-1:0] v);
        logic signed [ZPW-1:0] mn;
        mn = -MaxZ;
        if (v > MaxZ) return MaxZ[ZW-1:0];
        if (v < mn) return mn[ZW-1:0];
        return v[ZW-1:0];
    endfunction

    // One extra bit keeps o+/-step from wrapping near full scale.
    function automatic logic signed [W-1:0] slew(input logic signed [W-1:0] o,
                                                 input logic signed [W-1:0] tgt,
                                                 input logic [W-1:0] step);
        logic signed [W:0] s, hi, lo, t;
        s  = {2'b00, step[W-2:0]};
        hi = {o[W-1], o} + s;
        lo = {o[W-1], o} - s;
        t  = {tgt[W-1], tgt};
        if (t > hi) return hi[W-1:0];
        if (t < lo) return lo[W-1:0];
        return tgt;
    endfunction

    logic tick;
    if (RDECI == 0) begin : g_notick
        assign tick = 1'b1;
    end else begin : g_tick
        logic [RDECI-1:0] cnt_q;
        always_ff @(posedge a_clk) begin
            if (a_rst) cnt_q <= '0;
            else       cnt_q <= cnt_q + RDECI'(1);
        end
        assign tick = &cnt_q;
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXIS_Xs_tvalid, S_AXIS_Ys_tvalid, S_AXIS_Zs_tvalid,
                         xy_offset_step[W-1], z_offset_step[W-1]};

    // T1
    logic signed [W-1:0]   xs_q, ys_q, zg_q, zv_q, u_q, mxx_q, mxy_q, slx_q, sly_q;
    logic signed [W-1:0]   mx0_q, my0_q, mz0_q, mu0_q;
    logic [2:0]            settled_q;
    // T2
    logic signed [PW-1:0]  rrx_q, rry_q;
    logic signed [W-1:0]   ox2_q, oy2_q, oz2_q, ou2_q, zg2_q, zv2_q, u2_q, slx2_q, sly2_q;
    // T3
    logic signed [W-1:0]   rx3_q, ry3_q, oz3_q, ou3_q, zg3_q, zv3_q, u3_q;
    logic signed [ZW-1:0]  zs3_q;
    // T4
    logic signed [W-1:0]   outx_q, outy_q, outz_q, outu_q;
    logic                  zsat_q;
    logic [3:0]            valid_q;

    logic signed [W-1:0]   mx0_d, my0_d, mz0_d, rx_d, ry_d, rz_d, ru_d;
    logic signed [PW-1:0]  rrx_d, rry_d, xr, yr;
    logic signed [ZPW-1:0] zsf;
    logic signed [ZW-1:0]  zs_d;
    logic signed [SW-1:0]  zsum;
    logic                  zclip;

    always_comb begin
        mx0_d = slew(mx0_q, x0, xy_offset_step);
        my0_d = slew(my0_q, y0, xy_offset_step);
        mz0_d = slew(mz0_q, z0, z_offset_step);
        rrx_d = PW'(mxx_q) * PW'(xs_q) + PW'(mxy_q) * PW'(ys_q);
        rry_d = PW'(mxx_q) * PW'(ys_q) - PW'(mxy_q) * PW'(xs_q);
        xr    = rrx_q >>> QROTM;
        yr    = rry_q >>> QROTM;
        rx_d  = sat_w(xr + PW'(ox2_q));
        ry_d  = sat_w(yr + PW'(oy2_q));
        zsf   = (ZPW'(slx2_q) * ZPW'(xr) + ZPW'(sly2_q) * ZPW'(yr)) >>> QSLOPE;
        zs_d  = sat_z(zsf);
        // Guard bit above W+4 so four near-full-scale terms cannot wrap before the clamp.
        zsum  = SW'(oz3_q) + SW'(zg3_q) + SW'(zv3_q) + SW'(zs3_q);
        rz_d  = sat_w(PW'(zsum));
        zclip = PW'(zsum) != PW'(rz_d);
        ru_d  = sat_w(PW'(ou3_q) + PW'(u3_q));
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            xs_q   <= '0; ys_q   <= '0; zg_q   <= '0; zv_q   <= '0; u_q    <= '0;
            mxx_q  <= '0; mxy_q  <= '0; slx_q  <= '0; sly_q  <= '0;
            mx0_q  <= '0; my0_q  <= '0; mz0_q  <= '0; mu0_q  <= '0; settled_q <= '0;
            rrx_q  <= '0; rry_q  <= '0;
            ox2_q  <= '0; oy2_q  <= '0; oz2_q  <= '0; ou2_q  <= '0;
            zg2_q  <= '0; zv2_q  <= '0; u2_q   <= '0; slx2_q <= '0; sly2_q <= '0;
            rx3_q  <= '0; ry3_q  <= '0; zs3_q  <= '0; oz3_q  <= '0; ou3_q  <= '0;
            zg3_q  <= '0; zv3_q  <= '0; u3_q   <= '0;
            outx_q <= '0; outy_q <= '0; outz_q <= '0; outu_q <= '0;
            zsat_q <= 1'b0; valid_q <= '0;
        end else if (tick) begin
            xs_q   <= S_AXIS_Xs_tdata; ys_q  <= S_AXIS_Ys_tdata; zg_q <= S_AXIS_Zs_tdata;
            zv_q   <= S_AXIS_Z_tdata;  u_q   <= S_AXIS_U_tdata;
            mxx_q  <= rotmxx; mxy_q <= rotmxy; slx_q <= slope_x; sly_q <= slope_y;
            mx0_q  <= mx0_d; my0_q <= my0_d; mz0_q <= mz0_d; mu0_q <= u0;
            settled_q <= {mz0_d == z0, my0_d == y0, mx0_d == x0};
            rrx_q  <= rrx_d; rry_q <= rry_d;
            ox2_q  <= mx0_q; oy2_q <= my0_q; oz2_q <= mz0_q; ou2_q <= mu0_q;
            zg2_q  <= zg_q;  zv2_q <= zv_q;  u2_q  <= u_q;   slx2_q <= slx_q; sly2_q <= sly_q;
            rx3_q  <= rx_d;  ry3_q <= ry_d;  zs3_q <= zs_d;  oz3_q  <= oz2_q; ou3_q  <= ou2_q;
            zg3_q  <= zg2_q; zv3_q <= zv2_q; u3_q  <= u2_q;
            outx_q <= rx3_q; outy_q <= ry3_q; outz_q <= rz_d; outu_q <= ru_d;
            zsat_q <= zsat_q | zclip;
            valid_q <= {valid_q[2:0], 1'b1};
        end
    end

    assign M_AXIS1_tdata         = outx_q;
    assign M_AXIS2_tdata         = outy_q;
    assign M_AXIS3_tdata         = outz_q;
    assign M_AXIS4_tdata         = outu_q;
    assign M_AXIS1_tvalid        = valid_q[3];
    assign M_AXIS2_tvalid        = valid_q[3];
    assign M_AXIS3_tvalid        = valid_q[3];
    assign M_AXIS4_tvalid        = valid_q[3];
    assign M_AXIS_XSMON_tdata    = xs_q;
    assign M_AXIS_YSMON_tdata    = ys_q;
    assign M_AXIS_ZSMON_tdata    = zg_q;
    assign M_AXIS_X0MON_tdata    = mx0_q;
    assign M_AXIS_Y0MON_tdata    = my0_q;
    assign M_AXIS_Z0MON_tdata    = mz0_q;
    assign M_AXIS_UrefMON_tdata  = mu0_q;
    assign M_AXIS_XSMON_tvalid   = valid_q[0];
    assign M_AXIS_YSMON_tvalid   = valid_q[0];
    assign M_AXIS_ZSMON_tvalid   = valid_q[0];
    assign M_AXIS_X0MON_tvalid   = valid_q[0];
    assign M_AXIS_Y0MON_tvalid   = valid_q[0];
    assign M_AXIS_Z0MON_tvalid   = valid_q[0];
    assign M_AXIS_UrefMON_tvalid = valid_q[0];
    assign offset_settled        = settled_q;
    assign z_sat                 = zsat_q;

endmodule

// File: tb/tb_axis_spm_control_gen.sv
// Bench for axis_spm_control_gen: directed scenarios plus a randomized stream checked against
// an arithmetic reference model; a second instance with RDECI=4 covers decimation and reset.
module tb_axis_spm_control_gen;
    logic        clk = 1'b0;
    logic        a_rst = 1'b1;
    logic [31:0] xs = '0, ys = '0, zg = '0, zv = '0, uu = '0;
    logic [31:0] mxx = '0, mxy = '0, slx = '0, sly = '0;
    logic [31:0] x0 = '0, y0 = '0, z0 = '0, u0 = '0, xystep = '0, zstep = '0;

    // Index 0..3: X,Y,Z,U; 4..10: XS,YS,ZS,X0,Y0,Z0,Uref monitors.
    logic [31:0] d0 [0:10];
    logic        v0 [0:10];
    logic [31:0] d4 [0:10];
    logic        v4 [0:10];
    logic [2:0]  st0, st4;
    logic        zsat0, zsat4;

    int total = 0;
    int bad = 0;

    typedef struct {int x; int y; int z; int u;} exp_t;

    always #5 clk = ~clk;

    axis_spm_control_gen #(.W(32), .QROTM(28), .QSLOPE(22), .RDECI(0)) dut0 (
        .a_clk(clk), .a_rst(a_rst),
        .S_AXIS_Xs_tdata(xs), .S_AXIS_Xs_tvalid(1'b1),
        .S_AXIS_Ys_tdata(ys), .S_AXIS_Ys_tvalid(1'b1),
        .S_AXIS_Zs_tdata(zg), .S_AXIS_Zs_tvalid(1'b1),
        .S_AXIS_Z_tdata(zv), .S_AXIS_U_tdata(uu),
        .rotmxx(mxx), .rotmxy(mxy), .slope_x(slx), .slope_y(sly),
        .x0(x0), .y0(y0), .z0(z0), .u0(u0),
        .xy_offset_step(xystep), .z_offset_step(zstep),
        .M_AXIS1_tdata(d0[0]), .M_AXIS1_tvalid(v0[0]),
        .M_AXIS2_tdata(d0[1]), .M_AXIS2_tvalid(v0[1]),
        .M_AXIS3_tdata(d0[2]), .M_AXIS3_tvalid(v0[2]),
        .M_AXIS4_tdata(d0[3]), .M_AXIS4_tvalid(v0[3]),
        .M_AXIS_XSMON_tdata(d0[4]), .M_AXIS_XSMON_tvalid(v0[4]),
        .M_AXIS_YSMON_tdata(d0[5]), .M_AXIS_YSMON_tvalid(v0[5]),
        .M_AXIS_ZSMON_tdata(d0[6]), .M_AXIS_ZSMON_tvalid(v0[6]),
        .M_AXIS_X0MON_tdata(d0[7]), .M_AXIS_X0MON_tvalid(v0[7]),
        .M_AXIS_Y0MON_tdata(d0[8]), .M_AXIS_Y0MON_tvalid(v0[8]),
        .M_AXIS_Z0MON_tdata(d0[9]), .M_AXIS_Z0MON_tvalid(v0[9]),
        .M_AXIS_UrefMON_tdata(d0[10]), .M_AXIS_UrefMON_tvalid(v0[10]),
        .offset_settled(st0), .z_sat(zsat0)
    );

    axis_spm_control_gen #(.W(32), .QROTM(28), .QSLOPE(22), .RDECI(4)) dut4 (
        .a_clk(clk), .a_rst(a_rst),
        .S_AXIS_Xs_tdata(xs), .S_AXIS_Xs_tvalid(1'b1),
        .S_AXIS_Ys_tdata(ys), .S_AXIS_Ys_tvalid(1'b1),
        .S_AXIS_Zs_tdata(zg), .S_AXIS_Zs_tvalid(1'b1),
        .S_AXIS_Z_tdata(zv), .S_AXIS_U_tdata(uu),
        .rotmxx(mxx), .rotmxy(mxy), .slope_x(slx), .slope_y(sly),
        .x0(x0), .y0(y0), .z0(z0), .u0(u0),
        .xy_offset_step(xystep), .z_offset_step(zstep),
        .M_AXIS1_tdata(d4[0]), .M_AXIS1_tvalid(v4[0]),
        .M_AXIS2_tdata(d4[1]), .M_AXIS2_tvalid(v4[1]),
        .M_AXIS3_tdata(d4[2]), .M_AXIS3_tvalid(v4[2]),
        .M_AXIS4_tdata(d4[3]), .M_AXIS4_tvalid(v4[3]),
        .M_AXIS_XSMON_tdata(d4[4]), .M_AXIS_XSMON_tvalid(v4[4]),
        .M_AXIS_YSMON_tdata(d4[5]), .M_AXIS_YSMON_tvalid(v4[5]),
        .M_AXIS_ZSMON_tdata(d4[6]), .M_AXIS_ZSMON_tvalid(v4[6]),
        .M_AXIS_X0MON_tdata(d4[7]), .M_AXIS_X0MON_tvalid(v4[7]),
        .M_AXIS_Y0MON_tdata(d4[8]), .M_AXIS_Y0MON_tvalid(v4[8]),
        .M_AXIS_Z0MON_tdata(d4[9]), .M_AXIS_Z0MON_tvalid(v4[9]),
        .M_AXIS_UrefMON_tdata(d4[10]), .M_AXIS_UrefMON_tvalid(v4[10]),
        .offset_settled(st4), .z_sat(zsat4)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic zero_inputs();
        xs = '0; ys = '0; zg = '0; zv = '0; uu = '0; mxx = 32'h1000_0000; mxy = '0;
        slx = '0; sly = '0; x0 = '0; y0 = '0; z0 = '0; u0 = '0;
        xystep = 32'h7FFF_FFFF; zstep = 32'h7FFF_FFFF;
    endtask

    function automatic longint clampw(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483647) return -64'sd2147483647;
        return v;
    endfunction

    function automatic exp_t model(input int ixs, iys, izg, izv, iu, imxx, imxy, islx, isly,
                                   ix0, iy0, iz0, iu0);
        longint xr, yr, zsl;
        exp_t e;
        xr  = (longint'(imxx) * longint'(ixs) + longint'(imxy) * longint'(iys)) >>> 28;
        yr  = (longint'(imxx) * longint'(iys) - longint'(imxy) * longint'(ixs)) >>> 28;
        zsl = (longint'(islx) * xr + longint'(isly) * yr) >>> 22;
        e.x = int'(clampw(xr + longint'(ix0)));
        e.y = int'(clampw(yr + longint'(iy0)));
        e.z = int'(clampw(longint'(iz0) + longint'(izg) + longint'(izv) + zsl));
        e.u = int'(clampw(longint'(iu0) + longint'(iu)));
        return e;
    endfunction

    task automatic test_reset();
        zero_inputs();
        xs = 32'd77; x0 = 32'd55;
        a_rst = 1'b1;
        cyc(3);
        for (int k = 0; k < 11; k++) begin
            total++;
            if (d0[k] !== 32'd0 || v0[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_dut0[%0d]: got data=%0d valid=%b, want 0/0", k, d0[k], v0[k]);
            end
            total++;
            if (d4[k] !== 32'd0 || v4[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_dut4[%0d]: got data=%0d valid=%b, want 0/0", k, d4[k], v4[k]);
            end
        end
        total++;
        if (st0 !== 3'b000 || zsat0 !== 1'b0 || st4 !== 3'b000 || zsat4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: settled=%b/%b z_sat=%b/%b, want 0", st0, st4, zsat0, zsat4);
        end
    endtask

    task automatic test_identity();
        zero_inputs();
        xs = 32'd1000; ys = -32'sd500;
        a_rst = 1'b1; cyc(1); a_rst = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            cyc(1);
            total++;
            if (v0[0] !== (t == 4) || v0[4] !== 1'b1) begin
                bad++;
                $display("FAIL ident_valid tick%0d: out=%b mon=%b, want %b/1", t, v0[0], v0[4], t == 4);
            end
            total++;
            if ($signed(d0[0]) !== (t == 4 ? 1000 : 0)) begin
                bad++;
                $display("FAIL ident_x tick%0d: got %0d want %0d", t, $signed(d0[0]), t == 4 ? 1000 : 0);
            end
        end
        total++;
        if ($signed(d0[1]) !== -500) begin
            bad++;
            $display("FAIL ident_y: got %0d want -500", $signed(d0[1]));
        end
    endtask

    task automatic test_rotate90();
        mxx = '0; mxy = 32'h1000_0000; xs = 32'd1000; ys = '0;
        cyc(4);
        total++;
        if ($signed(d0[0]) !== 0 || $signed(d0[1]) !== -1000) begin
            bad++;
            $display("FAIL rot90: got X=%0d Y=%0d want 0/-1000", $signed(d0[0]), $signed(d0[1]));
        end
    endtask

    task automatic test_slew();
        int seq_x [11] = '{300, 600, 900, 1000, 500, 0, -200, -200, -200, -200, -200};
        int seq_s [11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
        zero_inputs();
        x0 = 32'd1000; xystep = 32'd300;
        a_rst = 1'b1; cyc(1); a_rst = 1'b0;
        for (int t = 0; t < 11; t++) begin
            if (t == 4) begin x0 = -32'sd200; xystep = 32'd500; end
            if (t == 7) begin x0 = 32'd5000; xystep = 32'd0; end
            if (t == 9) xystep = 32'h8000_0000;
            cyc(1);
            total++;
            if ($signed(d0[7]) !== seq_x[t] || st0[0] !== seq_s[t][0]) begin
                bad++;
                $display("FAIL slew step%0d: mx0=%0d settled=%b want %0d/%0d",
                         t, $signed(d0[7]), st0[0], seq_x[t], seq_s[t]);
            end
        end
    endtask

    task automatic test_zsat();
        zero_inputs();
        z0 = 32'h7FFF_0000; zv = 32'h7FFF_FFFF;
        a_rst = 1'b1; cyc(1); a_rst = 1'b0;
        cyc(3);
        total++;
        if (zsat0 !== 1'b0) begin
            bad++;
            $display("FAIL zsat_early: got %b want 0", zsat0);
        end
        cyc(1);
        total++;
        if (d0[2] !== 32'h7FFF_FFFF || zsat0 !== 1'b1) begin
            bad++;
            $display("FAIL zsat_pos: Z=%h z_sat=%b want 7fffffff/1", d0[2], zsat0);
        end
        z0 = '0; zv = '0;
        cyc(6);
        total++;
        if (d0[2] !== 32'd0 || zsat0 !== 1'b1) begin
            bad++;
            $display("FAIL zsat_sticky: Z=%h z_sat=%b want 0/1", d0[2], zsat0);
        end
        z0 = 32'h8001_0000; zv = 32'h8000_0000;
        cyc(5);
        total++;
        if (d0[2] !== 32'h8000_0001) begin
            bad++;
            $display("FAIL zsat_neg: Z=%h want 80000001", d0[2]);
        end
    endtask

    task automatic test_slope();
        zero_inputs();
        xs = 32'd2000; slx = 32'h0040_0000;
        cyc(5);
        total++;
        if ($signed(d0[2]) !== 2000) begin
            bad++;
            $display("FAIL slope_x: Z=%0d want 2000", $signed(d0[2]));
        end
        ys = 32'd2000; sly = -32'sh0020_0000;
        cyc(5);
        total++;
        if ($signed(d0[2]) !== 1000 || $signed(d0[1]) !== 2000) begin
            bad++;
            $display("FAIL slope_xy: Z=%0d Y=%0d want 1000/2000", $signed(d0[2]), $signed(d0[1]));
        end
    endtask

    task automatic test_stream();
        exp_t q[$];
        exp_t e, g;
        int sxs;
        zero_inputs();
        x0 = 32'($urandom_range(0, 32'h7FFF_FFFF)) - 32'h4000_0000;
        y0 = 32'($urandom_range(0, 32'h7FFF_FFFF)) - 32'h4000_0000;
        z0 = 32'($urandom_range(0, 32'h7FFF_FFFF)) - 32'h4000_0000;
        u0 = $urandom;
        cyc(2);
        for (int i = 0; i < 203; i++) begin
            if (i < 200) begin
                xs = $urandom; ys = $urandom; zg = $urandom; zv = $urandom; uu = $urandom;
                mxx = 32'($urandom_range(0, 1 << 29)) - 32'h1000_0000;
                mxy = 32'($urandom_range(0, 1 << 29)) - 32'h1000_0000;
                slx = 32'($urandom_range(0, 1 << 24)) - 32'h0080_0000;
                sly = 32'($urandom_range(0, 1 << 24)) - 32'h0080_0000;
            end
            q.push_back(model(xs, ys, zg, zv, uu, mxx, mxy, slx, sly, x0, y0, z0, u0));
            sxs = int'(xs);
            cyc(1);
            total++;
            if ($signed(d0[4]) !== sxs) begin
                bad++;
                $display("FAIL stream_xsmon %0d: got %0d want %0d", i, $signed(d0[4]), sxs);
            end
            if (q.size() == 4) begin
                e = q.pop_front();
                g.x = int'(d0[0]); g.y = int'(d0[1]); g.z = int'(d0[2]); g.u = int'(d0[3]);
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL stream %0d: got X=%0d Y=%0d Z=%0d U=%0d want %0d %0d %0d %0d",
                             i, g.x, g.y, g.z, g.u, e.x, e.y, e.z, e.u);
                end
            end
        end
        total++;
        if (v0[0] !== 1'b1 || st0 !== 3'b111) begin
            bad++;
            $display("FAIL stream_status: valid=%b settled=%b want 1/111", v0[0], st0);
        end
    endtask

    task automatic test_rdeci_reset();
        int n;
        zero_inputs();
        x0 = 32'd1000; xystep = 32'd300;
        a_rst = 1'b1; cyc(2); a_rst = 1'b0;
        n = 0;
        while (d4[7] !== 32'd600 && n < 100) begin cyc(1); n++; end
        total++;
        if (d4[7] !== 32'd600) begin
            bad++;
            $display("FAIL rdeci_reach600: got %0d want 600 within 100 cycles", d4[7]);
        end
        a_rst = 1'b1; cyc(1);
        for (int k = 0; k < 11; k++) begin
            total++;
            if (d4[k] !== 32'd0 || v4[k] !== 1'b0) begin
                bad++;
                $display("FAIL rdeci_reset[%0d]: data=%0d valid=%b want 0/0", k, d4[k], v4[k]);
            end
        end
        a_rst = 1'b0;
        n = 0;
        while (d4[7] === 32'd0 && n < 40) begin cyc(1); n++; end
        total++;
        if (n !== 16 || d4[7] !== 32'd300 || v4[4] !== 1'b1 || v4[0] !== 1'b0) begin
            bad++;
            $display("FAIL rdeci_first_tick: cycles=%0d mx0=%0d mon_v=%b out_v=%b want 16/300/1/0",
                     n, d4[7], v4[4], v4[0]);
        end
        cyc(47);
        total++;
        if (v4[0] !== 1'b0 || d4[7] !== 32'd900) begin
            bad++;
            $display("FAIL rdeci_pre4: valid=%b mx0=%0d want 0/900", v4[0], d4[7]);
        end
        cyc(1);
        total++;
        if (v4[0] !== 1'b1 || d4[7] !== 32'd1000 || st4[0] !== 1'b1) begin
            bad++;
            $display("FAIL rdeci_tick4: valid=%b mx0=%0d settled=%b want 1/1000/1",
                     v4[0], d4[7], st4[0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_rotate90();
        test_slew();
        test_zsat();
        test_slope();
        test_stream();
        test_rdeci_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
